log_fp_muldiv_serial: RTL and testbench
=======================================

Name: log_fp_muldiv_serial

Overview:
- Parametrised successor to the byte-serial logarithmic (Mitchell) FP16 multiplier.
- Generic IEEE-like format: 1 sign bit, EXP_W exponent bits, MAN_W mantissa bits.
- Adds a divide mode, IEEE special-case handling, overflow/underflow saturation with status flags, and valid/ready handshakes on both byte streams.
- Sits between the top-level pin wrapper and the byte I/O pins.

Parameters:
EXP_W, 5, exponent field width (>=3).
MAN_W, 10, mantissa field width (>=2).
BIAS, 2**(EXP_W-1)-1, exponent bias.
(Derived, not overridable: W=1+EXP_W+MAN_W; NB=ceil(W/8); EMAX=2**EXP_W-1.)

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  a_byte/b_byte/op are valid.
in_ready  out  1  block accepts an input byte pair.
a_byte  in  8  operand A byte, LSB byte first.
b_byte  in  8  operand B byte, LSB byte first.
op  in  1  0 = multiply, 1 = divide (A/B); sampled with first byte only.
out_valid  out  1  out_byte valid.
out_ready  in  1  consumer accepts out_byte.
out_byte  out  8  result byte, LSB byte first.
flags  out  3  {invalid, overflow, underflow}; valid while out_valid=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_byte=0, flags=0, operand/result registers=0.
- Reset mid-operation aborts the transaction; no partial output.
- All outputs are registered.
- FSM: IDLE -> LOAD -> DECODE -> COMPUTE -> NORM -> PACK -> SEND -> IDLE.
- IDLE/LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready handshake stores byte i (i=0..NB-1) of A and of B.
  - First handshake latches op and moves to LOAD.
  - After byte NB-1, in_ready drops on the next edge.
  - Top-byte bits above W are ignored.
- DECODE: split sign/exponent/mantissa; classify each operand: zero (e=0, mantissa ignored, subnormals flushed) or max (e=EMAX, Inf/NaN treated alike).
- COMPUTE, multiply:
  - {c,f} = ma+mb over MAN_W+1 bits.
  - E = ea+eb-BIAS+c; mantissa = f (carry dropped).
- COMPUTE, divide:
  - {bw,f} = ma-mb mod 2**MAN_W; bw = borrow.
  - E = ea-eb+BIAS-bw; mantissa = f.
- E is signed, EXP_W+2 bits.
- NORM, sign = sa^sb, except NaN sign = 0:
  - mul: (max & zero) -> NaN, invalid=1; any max -> Inf; any zero -> Zero.
  - div: (max/max) or (zero/zero) -> NaN, invalid=1; A max or B zero -> Inf; A zero or B max -> Zero.
  - Finite path: E >= EMAX -> Inf, overflow=1; E <= 0 -> Zero, underflow=1.
  - NaN = exponent EMAX, mantissa MSB only. Inf = exponent EMAX, mantissa 0. Zero = all exponent/mantissa bits 0.
- PACK: result = {sign,E,mantissa}; zero-padded to NB*8; flags registered.
- SEND:
  - out_valid=1 with out_byte = byte j.
  - Handshake out_valid&&out_ready advances j.
  - With out_ready=0, out_byte and flags hold stable.
  - After byte NB-1 handshake: out_valid=0, flags=0, next state IDLE, in_ready=1 on the following edge.
- Latency: final input handshake at edge k -> out_valid=1 from edge k+4.
- in_valid outside IDLE/LOAD is ignored; no input is accepted while SEND is pending.

Test Plan:
1. Default params, mul 0x3E00*0x3E00 (a bytes 00,3E) -> out bytes 00,40; flags 000. Mitchell result 2.0. Also check 0x4000*0x4200 -> 0x4600 and 0xC000*0x4000 -> 0xC400.
2. Divide: 0x4600/0x4000 -> 0x4200; 0x3C00/0x3E00 -> 0x3A00 (borrow path); flags 000.
3. Specials:
   - 0x0000/0x0000 -> 0x7E00, flags 100.
   - 0x0000*0x7C00 -> 0x7E00, flags 100.
   - 0x4000/0x0000 -> 0x7C00, flags 000.
   - 0x8000*0x4000 -> 0x8000.
4. Saturation: 0x7800*0x7800 -> 0x7C00, flags 010; 0x0400*0x0400 -> 0x0000, flags 001.
5. Handshake and latency:
   - Gap in in_valid between bytes -> same result.
   - out_valid exactly 4 cycles after the last input handshake.
   - out_ready low for 3 cycles -> out_byte 0x00 held, then 0x40.
   - in_ready low until the final output handshake.
6. rst_n pulsed during COMPUTE -> out_valid stays 0 and in_ready=1 immediately; next transaction correct. Rerun case 1 with EXP_W=8, MAN_W=7: 0x3FC0*0x3FC0 -> 0x4000.

Source files
------------

// File: rtl/log_fp_muldiv_serial_if.sv
// Byte-stream bundle for the serial log-domain FP multiplier/divider.
// Carries operand bytes + op on the input side and result bytes + flags on the output side.
// Both directions use valid/ready; the master is the side that feeds operands and drains results.
interface log_fp_muldiv_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [2:0] flags;

    modport master (
        output in_valid, a_byte, b_byte, op, out_ready,
        input  in_ready, out_valid, out_byte, flags
    );

    modport slave (
        input  in_valid, a_byte, b_byte, op, out_ready,
        output in_ready, out_valid, out_byte, flags
    );
endinterface

// File: rtl/log_fp_muldiv_serial.sv
// Byte-serial Mitchell-approximation FP multiply/divide with IEEE-like specials and saturation.
// Latency: last input byte accepted at edge k -> first result byte valid from edge k+4.
// Backpressure: in_ready low from last input byte until last output byte is taken; out_ready low holds out_byte/flags.
module log_fp_muldiv_serial #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    log_fp_muldiv_serial_if.slave        bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int NB   = (W + 7) / 8;
    localparam int EMAX = 2**EXP_W - 1;
    localparam int EW   = EXP_W + 2;
    localparam logic [7:0]           LAST   = 8'(NB - 1);
    localparam logic [EW-1:0]        BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
    localparam logic signed [EW-1:0] ZERO_E = '0;

    typedef enum logic [2:0] {IDLE, LOAD, DECODE, COMPUTE, NORM, PACK, SEND} state_t;

    state_t state, state_nxt;

    logic [7:0]        idx;
    logic [7:0]        idx_inc;
    logic [NB*8-1:0]   a_reg, b_reg;
    logic [W-1:0]      a_w, b_w;
    logic              op_q;
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  ma, mb;
    logic              za, zb, xa, xb;
    logic [MAN_W:0]    sum, dif;
    logic [EW-1:0]     e_mul, e_div;
    logic signed [EW-1:0] e_q;
    logic [MAN_W-1:0]  f_q;
    logic              sgn_q;
    logic              is_nan, is_inf, is_zero;
    logic              n_sign;
    logic [EXP_W-1:0]  n_exp;
    logic [MAN_W-1:0]  n_man;
    logic [2:0]        n_flags;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [MAN_W-1:0]  r_man;
    logic [2:0]        r_flags;
    logic [NB*8-1:0]   packed_res, res_q;
    logic              in_ready_q, out_valid_q;
    logic [7:0]        out_byte_q;
    logic [2:0]        flags_q;
    logic              in_fire, out_fire;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.flags     = flags_q;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;
    assign idx_inc  = idx + 8'd1;
    assign a_w      = a_reg[W-1:0];
    assign b_w      = b_reg[W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: byte collection, fixed pipeline walk, then byte emission.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire) state_nxt = (idx == LAST) ? DECODE : LOAD;
            LOAD:    if (in_fire && idx == LAST) state_nxt = DECODE;
            DECODE:  state_nxt = COMPUTE;
            COMPUTE: state_nxt = NORM;
            NORM:    state_nxt = PACK;
            PACK:    state_nxt = SEND;
            SEND:    if (out_fire && idx == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Log-domain arithmetic: mantissa add/sub stands in for multiply/divide, carry/borrow fixes the exponent.
    always_comb begin
        sum   = {1'b0, ma} + {1'b0, mb};
        dif   = {1'b0, ma} - {1'b0, mb};
        e_mul = {2'b00, ea} + {2'b00, eb} - BIAS_E + EW'(sum[MAN_W]);
        e_div = {2'b00, ea} - {2'b00, eb} + BIAS_E - EW'(dif[MAN_W]);
    end

    // Special-case classification and exponent saturation; NaN outranks Inf outranks Zero.
    always_comb begin
        n_sign  = sgn_q;
        n_exp   = e_q[EXP_W-1:0];
        n_man   = f_q;
        n_flags = 3'b000;
        if (op_q) begin
            is_nan  = (xa & xb) | (za & zb);
            is_inf  = xa | zb;
            is_zero = za | xb;
        end else begin
            is_nan  = (xa & zb) | (za & xb);
            is_inf  = xa | xb;
            is_zero = za | zb;
        end
        if (is_nan) begin
            n_sign  = 1'b0;
            n_exp   = '1;
            n_man   = {1'b1, {(MAN_W-1){1'b0}}};
            n_flags = 3'b100;
        end else if (is_inf) begin
            n_exp = '1;
            n_man = '0;
        end else if (is_zero) begin
            n_exp = '0;
            n_man = '0;
        end else if (e_q >= EMAX_E) begin
            n_exp   = '1;
            n_man   = '0;
            n_flags = 3'b010;
        end else if (e_q <= ZERO_E) begin
            n_exp   = '0;
            n_man   = '0;
            n_flags = 3'b001;
        end
    end

    // Result word, zero-padded up to a whole number of bytes.
    always_comb begin
        packed_res        = '0;
        packed_res[W-1:0] = {r_sign, r_exp, r_man};
    end

    // Datapath and registered outputs, advanced one stage per FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_q        <= 1'b0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            ea          <= '0;
            eb          <= '0;
            ma          <= '0;
            mb          <= '0;
            za          <= 1'b0;
            zb          <= 1'b0;
            xa          <= 1'b0;
            xb          <= 1'b0;
            e_q         <= '0;
            f_q         <= '0;
            sgn_q       <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_man       <= '0;
            r_flags     <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            flags_q     <= '0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE) || (state_nxt == LOAD);
            out_valid_q <= (state_nxt == SEND);
            case (state)
                IDLE, LOAD: begin
                    if (in_fire) begin
                        for (int i = 0; i < NB; i++) begin
                            if (idx == 8'(i)) begin
                                a_reg[i*8 +: 8] <= bus.a_byte;
                                b_reg[i*8 +: 8] <= bus.b_byte;
                            end
                        end
                        if (state == IDLE) op_q <= bus.op;
                        idx <= (idx == LAST) ? 8'd0 : idx_inc;
                    end
                end
                DECODE: begin
                    sa <= a_w[W-1];
                    sb <= b_w[W-1];
                    ea <= a_w[W-2 -: EXP_W];
                    eb <= b_w[W-2 -: EXP_W];
                    ma <= a_w[MAN_W-1:0];
                    mb <= b_w[MAN_W-1:0];
                    za <= (a_w[W-2 -: EXP_W] == '0);
                    zb <= (b_w[W-2 -: EXP_W] == '0);
                    xa <= (a_w[W-2 -: EXP_W] == '1);
                    xb <= (b_w[W-2 -: EXP_W] == '1);
                end
                COMPUTE: begin
                    e_q   <= op_q ? e_div : e_mul;
                    f_q   <= op_q ? dif[MAN_W-1:0] : sum[MAN_W-1:0];
                    sgn_q <= sa ^ sb;
                end
                NORM: begin
                    r_sign  <= n_sign;
                    r_exp   <= n_exp;
                    r_man   <= n_man;
                    r_flags <= n_flags;
                end
                PACK: begin
                    res_q      <= packed_res;
                    out_byte_q <= packed_res[7:0];
                    flags_q    <= r_flags;
                    idx        <= '0;
                end
                SEND: begin
                    if (out_fire) begin
                        if (idx == LAST) begin
                            idx        <= '0;
                            out_byte_q <= '0;
                            flags_q    <= '0;
                        end else begin
                            idx <= idx_inc;
                            for (int i = 0; i < NB; i++) begin
                                if (idx_inc == 8'(i)) out_byte_q <= res_q[i*8 +: 8];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_log_fp_muldiv_serial.sv
// Directed bench for log_fp_muldiv_serial: FP16 default instance plus an 8/7 format instance.
// Expected values are hand-derived Mitchell results for each vector.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_log_fp_muldiv_serial;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    log_fp_muldiv_serial_if b16();
    log_fp_muldiv_serial_if b8();

    log_fp_muldiv_serial dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    log_fp_muldiv_serial #(.EXP_W(8), .MAN_W(7)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    // Feed the two operand bytes; op flips on the second byte, which must be ignored.
    task automatic send_bytes(input logic [15:0] a, input logic [15:0] bb, input logic o,
                              input int gap, output bit to);
        int n;
        to = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b16.in_valid = 1'b1;
            b16.a_byte   = a[i*8 +: 8];
            b16.b_byte   = bb[i*8 +: 8];
            b16.op       = (i == 0) ? o : ~o;
            n = 0;
            while (b16.in_ready !== 1'b1 && n < 50) begin
                @(posedge clk); @(negedge clk); n++;
            end
            if (n >= 50) to = 1'b1;
            @(posedge clk); @(negedge clk);
            b16.in_valid = 1'b0;
            b16.a_byte   = 8'hA5;
            b16.b_byte   = 8'h5A;
            if (i == 0) repeat (gap) @(negedge clk);
        end
    endtask

    // Count edges from the final input handshake until out_valid; optionally hold junk on in_valid.
    task automatic wait_out(input bit junk, output int lat, output bit rdy_bad);
        lat = 0;
        rdy_bad = 1'b0;
        b16.in_valid = junk;
        b16.a_byte   = 8'hFF;
        b16.b_byte   = 8'hFF;
        if (b16.in_ready !== 1'b0) rdy_bad = 1'b1;
        while (b16.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); @(negedge clk); lat++;
            if (b16.in_ready !== 1'b0) rdy_bad = 1'b1;
        end
    endtask

    // Drain the two result bytes, stalling out_ready before the first one.
    task automatic recv(input int stall, output logic [15:0] res, output logic [2:0] fl,
                        output bit hold_bad, output bit rdy_bad, output bit post_bad, output bit to);
        int n;
        logic [7:0] hb;
        logic [2:0] hf;
        b16.in_valid = 1'b0;
        hold_bad = 1'b0; rdy_bad = 1'b0; post_bad = 1'b0; to = 1'b0;
        res = 'x; fl = 'x;
        for (int j = 0; j < 2; j++) begin
            n = 0;
            while (b16.out_valid !== 1'b1 && n < 50) begin
                @(posedge clk); @(negedge clk); n++;
            end
            if (n >= 50) to = 1'b1;
            if (j == 0) begin
                hb = b16.out_byte;
                hf = b16.flags;
                for (int s = 0; s < stall; s++) begin
                    b16.out_ready = 1'b0;
                    @(posedge clk); @(negedge clk);
                    if (b16.out_byte !== hb || b16.flags !== hf || b16.out_valid !== 1'b1)
                        hold_bad = 1'b1;
                end
                fl = b16.flags;
            end
            res[j*8 +: 8] = b16.out_byte;
            if (b16.in_ready !== 1'b0) rdy_bad = 1'b1;
            b16.out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            b16.out_ready = 1'b0;
        end
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.flags !== 3'b000) post_bad = 1'b1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] bb, input logic o,
                          output logic [15:0] res, output logic [2:0] fl, output bit to);
        bit t1, t2, d0, d1, d2;
        int lat;
        send_bytes(a, bb, o, 0, t1);
        wait_out(1'b0, lat, d0);
        recv(0, res, fl, d1, d2, d0, t2);
        to = t1 | t2 | (lat >= 50);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        b16.in_valid = 1'b0; b16.a_byte = '0; b16.b_byte = '0; b16.op = 1'b0; b16.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.a_byte  = '0; b8.b_byte  = '0; b8.op  = 1'b0; b8.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.out_byte !== 8'h00 || b16.flags !== 3'b000) begin
            $display("FAIL reset: in_ready=%b out_valid=%b out_byte=%h flags=%b, want 1 0 00 000",
                     b16.in_ready, b16.out_valid, b16.out_byte, b16.flags);
            fails++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] ev [3];
        logic [15:0] res;
        logic [2:0]  fl;
        bit to;
        av = '{16'h3E00, 16'h4000, 16'hC000};
        bv = '{16'h3E00, 16'h4200, 16'h4000};
        ev = '{16'h4000, 16'h4600, 16'hC400};
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], 1'b0, res, fl, to);
            tests++;
            if (to || res !== ev[i] || fl !== 3'b000) begin
                $display("FAIL mul %h*%h: got %h flags %b timeout %0d, want %h flags 000",
                         av[i], bv[i], res, fl, to, ev[i]);
                fails++;
            end
        end
    endtask

    task automatic test_div;
        logic [15:0] av [2];
        logic [15:0] bv [2];
        logic [15:0] ev [2];
        logic [15:0] res;
        logic [2:0]  fl;
        bit to;
        av = '{16'h4600, 16'h3C00};
        bv = '{16'h4000, 16'h3E00};
        ev = '{16'h4200, 16'h3A00};
        for (int i = 0; i < 2; i++) begin
            run_op(av[i], bv[i], 1'b1, res, fl, to);
            tests++;
            if (to || res !== ev[i] || fl !== 3'b000) begin
                $display("FAIL div %h/%h: got %h flags %b timeout %0d, want %h flags 000",
                         av[i], bv[i], res, fl, to, ev[i]);
                fails++;
            end
        end
    endtask

    task automatic test_specials;
        logic [15:0] av [6];
        logic [15:0] bv [6];
        logic        ov [6];
        logic [15:0] ev [6];
        logic [2:0]  fv [6];
        logic [15:0] res;
        logic [2:0]  fl;
        bit to;
        av = '{16'h0000, 16'h0000, 16'h4000, 16'h8000, 16'h7C00, 16'h4000};
        bv = '{16'h0000, 16'h7C00, 16'h0000, 16'h4000, 16'hFC00, 16'h7C00};
        ov = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
        ev = '{16'h7E00, 16'h7E00, 16'h7C00, 16'h8000, 16'h7E00, 16'h0000};
        fv = '{3'b100,   3'b100,   3'b000,   3'b000,   3'b100,   3'b000};
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], bv[i], ov[i], res, fl, to);
            tests++;
            if (to || res !== ev[i] || fl !== fv[i]) begin
                $display("FAIL special %h op%0d %h: got %h flags %b timeout %0d, want %h flags %b",
                         av[i], ov[i], bv[i], res, fl, to, ev[i], fv[i]);
                fails++;
            end
        end
    endtask

    task automatic test_saturation;
        logic [15:0] av [6];
        logic [15:0] bv [6];
        logic [15:0] ev [6];
        logic [2:0]  fv [6];
        logic [15:0] res;
        logic [2:0]  fl;
        bit to;
        av = '{16'h7800, 16'h0400, 16'h5C00, 16'h5800, 16'h2000, 16'h1C00};
        bv = '{16'h7800, 16'h0400, 16'h5C00, 16'h5C00, 16'h2000, 16'h2000};
        ev = '{16'h7C00, 16'h0000, 16'h7C00, 16'h7800, 16'h0400, 16'h0000};
        fv = '{3'b010,   3'b001,   3'b010,   3'b000,   3'b000,   3'b001};
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], bv[i], 1'b0, res, fl, to);
            tests++;
            if (to || res !== ev[i] || fl !== fv[i]) begin
                $display("FAIL sat %h*%h: got %h flags %b timeout %0d, want %h flags %b",
                         av[i], bv[i], res, fl, to, ev[i], fv[i]);
                fails++;
            end
        end
    endtask

    task automatic test_handshake;
        logic [15:0] res;
        logic [2:0]  fl;
        bit t1, t2, r1, r2, hold_bad, post_bad;
        int lat;
        send_bytes(16'h3E00, 16'h3E00, 1'b0, 3, t1);
        wait_out(1'b1, lat, r1);
        recv(3, res, fl, hold_bad, r2, post_bad, t2);
        tests++;
        if (t1 || t2 || res !== 16'h4000 || fl !== 3'b000) begin
            $display("FAIL hs_result: got %h flags %b timeout %0d, want 4000 flags 000", res, fl, t1 | t2);
            fails++;
        end
        tests++;
        if (lat !== 4) begin
            $display("FAIL hs_latency: got %0d edges, want 4", lat);
            fails++;
        end
        tests++;
        if (hold_bad) begin
            $display("FAIL hs_hold: out_byte/flags changed under out_ready=0, want held 00");
            fails++;
        end
        tests++;
        if (r1 || r2) begin
            $display("FAIL hs_in_ready: in_ready high before last output handshake, want 0");
            fails++;
        end
        tests++;
        if (post_bad) begin
            $display("FAIL hs_post: in_ready=%b out_valid=%b flags=%b, want 1 0 000",
                     b16.in_ready, b16.out_valid, b16.flags);
            fails++;
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] res;
        logic [2:0]  fl;
        bit to, vbad;
        send_bytes(16'h3E00, 16'h3E00, 1'b0, 0, to);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
            $display("FAIL reset_mid: in_ready=%b out_valid=%b, want 1 0", b16.in_ready, b16.out_valid);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        vbad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) vbad = 1'b1;
        end
        tests++;
        if (vbad) begin
            $display("FAIL reset_mid_quiet: partial output or in_ready low after abort, want idle");
            fails++;
        end
        run_op(16'h4000, 16'h4200, 1'b0, res, fl, to);
        tests++;
        if (to || res !== 16'h4600 || fl !== 3'b000) begin
            $display("FAIL reset_mid_next: got %h flags %b timeout %0d, want 4600 flags 000", res, fl, to);
            fails++;
        end
    endtask

    task automatic test_alt_format;
        logic [15:0] av [2];
        logic [15:0] bv [2];
        logic        ov [2];
        logic [15:0] ev [2];
        logic [15:0] res;
        logic [2:0]  fl;
        int n;
        av = '{16'h3FC0, 16'h4000};
        bv = '{16'h3FC0, 16'h3F80};
        ov = '{1'b0,     1'b1};
        ev = '{16'h4000, 16'h4000};
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                b8.in_valid = 1'b1;
                b8.a_byte   = av[i][k*8 +: 8];
                b8.b_byte   = bv[i][k*8 +: 8];
                b8.op       = ov[i];
                n = 0;
                while (b8.in_ready !== 1'b1 && n < 50) begin
                    @(posedge clk); @(negedge clk); n++;
                end
                @(posedge clk); @(negedge clk);
            end
            b8.in_valid = 1'b0;
            res = 'x; fl = 'x;
            for (int k = 0; k < 2; k++) begin
                n = 0;
                while (b8.out_valid !== 1'b1 && n < 50) begin
                    @(posedge clk); @(negedge clk); n++;
                end
                if (k == 0) fl = b8.flags;
                res[k*8 +: 8] = b8.out_byte;
                @(posedge clk); @(negedge clk);
            end
            tests++;
            if (res !== ev[i] || fl !== 3'b000) begin
                $display("FAIL e8m7 %h op%0d %h: got %h flags %b, want %h flags 000",
                         av[i], ov[i], bv[i], res, fl, ev[i]);
                fails++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_specials;
        test_saturation;
        test_handshake;
        test_reset_mid;
        test_alt_format;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
